playback_scheduler: RTL and testbench

PLAYBACK_SCHEDULER -- requirements
Module: playback_scheduler

---
 rtl/playback_scheduler.sv | 137 +++++++++++++
 tb/tb_playback_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_scheduler.sv
// Note playback sequencer with keypad echo. Plays a snapshot of up to eight 4-bit notes, each followed by a silent gap.
// Optional feature: define KEY_ECHO_EN to compile in the ECHO state that sounds accepted keypad codes.
module playback_scheduler #(
  parameter int TICK_DIV  = 2,
  parameter int ON_TICKS  = 1,
  parameter int GAP_TICKS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] note_reg,
  input  logic [2:0]  last_index,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  piezo_out,
  output logic [3:0]  led_out,
  output logic        busy,
  output logic        done,
  output logic        key_grant,
  output logic [3:0]  key_code_out,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    NOTE_ON  = 2'd1,
    NOTE_GAP = 2'd2,
    ECHO     = 2'd3
  } state_t;

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  state_t        state;
  logic [TW-1:0] ticker;
  logic          tick;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] tcnt_nxt;
  logic [2:0]    idx;
  logic [31:0]   snap_notes;
  logic [2:0]    snap_last;

  // Handshake: start and key_valid are single-cycle requests sampled on the
  // rising edge; they are honoured only when busy is low, start first.
  assign tick      = (ticker == TW'(TICK_DIV - 1));
  assign tcnt_nxt  = tcnt + 1'b1;
  assign led_out   = piezo_out;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset || tick) ticker <= '0;
    else               ticker <= ticker + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tcnt         <= '0;
      idx          <= '0;
      snap_notes   <= '0;
      snap_last    <= '0;
      piezo_out    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      key_grant    <= 1'b0;
      key_code_out <= '0;
    end else begin
      done      <= 1'b0;
      key_grant <= 1'b0;
      case (state)
        IDLE, ECHO: begin
          if (start) begin
            snap_notes <= note_reg;
            snap_last  <= last_index;
            idx        <= '0;
            tcnt       <= '0;
            state      <= NOTE_ON;
            piezo_out  <= note_reg[3:0];
            busy       <= 1'b1;
          end else if (key_valid) begin
            key_grant    <= 1'b1;
            key_code_out <= key_code;
`ifdef KEY_ECHO_EN
            state     <= ECHO;
            tcnt      <= '0;
            piezo_out <= key_code;
`else
            state     <= IDLE;
            piezo_out <= '0;
`endif
          end else if (state == ECHO && tick) begin
            if (tcnt_nxt == CW'(ON_TICKS)) begin
              state     <= IDLE;
              tcnt      <= '0;
              piezo_out <= '0;
            end else begin
              tcnt <= tcnt_nxt;
            end
          end
        end
        NOTE_ON: begin
          if (tick) begin
            if (tcnt_nxt == CW'(ON_TICKS)) begin
              state     <= NOTE_GAP;
              tcnt      <= '0;
              piezo_out <= '0;
            end else begin
              tcnt <= tcnt_nxt;
            end
          end
        end
        NOTE_GAP: begin
          if (tick) begin
            if (tcnt_nxt == CW'(GAP_TICKS)) begin
              tcnt <= '0;
              // idx only advances while below snap_last (at most 7), so it never wraps.
              if (idx == snap_last) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                idx       <= idx + 1'b1;
                state     <= NOTE_ON;
                piezo_out <= snap_notes[4*(idx + 3'd1) +: 4];
              end
            end else begin
              tcnt <= tcnt_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playback_scheduler.sv
// Directed bench for playback_scheduler: a segment-queue model is compared every cycle,
// plus literal tone sequences and pulse counts per scenario.
module tb_playback_scheduler;

  localparam int TICK_DIV  = 2;
  localparam int ON_TICKS  = 1;
  localparam int GAP_TICKS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] note_reg;
  logic [2:0]  last_index;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  piezo_out;
  logic [3:0]  led_out;
  logic        busy;
  logic        done;
  logic        key_grant;
  logic [3:0]  key_code_out;
  logic [1:0]  state_dbg;

  playback_scheduler #(
    .TICK_DIV (TICK_DIV),
    .ON_TICKS (ON_TICKS),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .note_reg    (note_reg),
    .last_index  (last_index),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .piezo_out   (piezo_out),
    .led_out     (led_out),
    .busy        (busy),
    .done        (done),
    .key_grant   (key_grant),
    .key_code_out(key_code_out),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // Model: playback is a queue of (tone, ticks) segments; the head segment sounds.
  int         m_phase;
  logic [3:0] seg_val[$];
  int         seg_len[$];
  bit         m_playing;
  bit         m_done;
  bit         m_grant;
  logic [3:0] m_kco;

  always @(posedge clk) begin
    bit t;
    if (reset) begin
      m_phase = 0;
      seg_val.delete();
      seg_len.delete();
      m_playing = 0;
      m_done = 0;
      m_grant = 0;
      m_kco = 4'h0;
    end else begin
      t = (m_phase == TICK_DIV - 1);
      m_phase = t ? 0 : m_phase + 1;
      m_done = 0;
      m_grant = 0;
      if (!m_playing && start) begin
        seg_val.delete();
        seg_len.delete();
        for (int i = 0; i <= int'(last_index); i++) begin
          seg_val.push_back(note_reg[4*i +: 4]);
          seg_len.push_back(ON_TICKS);
          seg_val.push_back(4'h0);
          seg_len.push_back(GAP_TICKS);
        end
        m_playing = 1;
      end else if (!m_playing && key_valid) begin
        m_grant = 1;
        m_kco = key_code;
        seg_val.delete();
        seg_len.delete();
`ifdef KEY_ECHO_EN
        seg_val.push_back(key_code);
        seg_len.push_back(ON_TICKS);
`endif
      end else if (t && seg_len.size() > 0) begin
        seg_len[0] = seg_len[0] - 1;
        if (seg_len[0] == 0) begin
          void'(seg_val.pop_front());
          void'(seg_len.pop_front());
          if (m_playing && seg_len.size() == 0) begin
            m_playing = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  // Scoreboard
  int         n_cmp = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         grant_cnt = 0;
  logic [3:0] prev_piezo = 4'h0;
  logic [3:0] trace_q[$];
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic [3:0] e_piezo;
    e_piezo = (seg_val.size() > 0) ? seg_val[0] : 4'h0;
    check("piezo", piezo_out, e_piezo);
    check("led", led_out, e_piezo);
    check("busy", busy, m_playing);
    check("done", done, m_done);
    check("key_grant", key_grant, m_grant);
    check("key_code_out", key_code_out, m_kco);
    if (done === 1'b1) done_cnt++;
    if (key_grant === 1'b1) grant_cnt++;
    if (piezo_out !== prev_piezo) trace_q.push_back(piezo_out);
    prev_piezo = piezo_out;
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: busy still high after %0d cycles", name, budget);
    end
  endtask

  task automatic check_trace(input string name, input int base);
    check({name, "_len"}, trace_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < trace_q.size(); i++)
      check(name, trace_q[base + i], exp_q[i]);
  endtask

  int tb_base, d_base, g_base, k;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    note_reg = 32'h0;
    last_index = 3'd0;
    key_valid = 1'b0;
    key_code = 4'h0;
    steps(3);
    reset = 1'b0;
    check("rst_piezo", piezo_out, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_kco", key_code_out, 4'h0);

    // Three-note playback
    tb_base = trace_q.size(); d_base = done_cnt;
    note_reg = 32'h87654321; last_index = 3'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("a_busy", busy, 1'b1);
    check("a_first", piezo_out, 4'h1);
    wait_idle("a_idle", 200);
    steps(4);
    exp_q = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0};
    check_trace("a_trace", tb_base);
    check("a_done_cnt", done_cnt - d_base, 1);

    // Keypad echo from IDLE
    tb_base = trace_q.size(); g_base = grant_cnt;
    key_code = 4'h5; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("b_grant", key_grant, 1'b1);
    check("b_kco", key_code_out, 4'h5);
    steps(8);
`ifdef KEY_ECHO_EN
    exp_q = '{4'h5, 4'h0};
`else
    exp_q.delete();
`endif
    check_trace("b_trace", tb_base);
    check("b_grant_cnt", grant_cnt - g_base, 1);

    // Key during the gap is ignored
    tb_base = trace_q.size(); g_base = grant_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (piezo_out !== 4'h0 && k < 20) begin step(); k++; end
    check("c_in_gap", piezo_out, 4'h0);
    key_code = 4'h9; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("c_grant", key_grant, 1'b0);
    check("c_kco", key_code_out, 4'h5);
    wait_idle("c_idle", 200);
    steps(4);
    exp_q = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0};
    check_trace("c_trace", tb_base);
    check("c_grant_cnt", grant_cnt - g_base, 0);

    // Start beats key in the same cycle
    g_base = grant_cnt;
    start = 1'b1; key_valid = 1'b1; key_code = 4'h3;
    step();
    start = 1'b0; key_valid = 1'b0;
    check("d_grant", key_grant, 1'b0);
    check("d_busy", busy, 1'b1);
    check("d_kco", key_code_out, 4'h5);
    wait_idle("d_idle", 200);
    steps(2);
    check("d_grant_cnt", grant_cnt - g_base, 0);

    // Reset during NOTE_ON
    d_base = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    check("e_note_on", piezo_out, 4'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("e_piezo", piezo_out, 4'h0);
    check("e_busy", busy, 1'b0);
    check("e_done", done, 1'b0);
    check("e_state", state_dbg, 2'd0);
    steps(10);
    check("e_done_cnt", done_cnt - d_base, 0);

    // Eight notes from the snapshot while inputs change
    tb_base = trace_q.size(); d_base = done_cnt;
    note_reg = 32'hFEDCBA98; last_index = 3'd7; start = 1'b1;
    step();
    start = 1'b0;
    steps(10);
    note_reg = 32'h0; last_index = 3'd0;
    wait_idle("f_idle", 300);
    steps(4);
    exp_q = '{4'h8, 4'h0, 4'h9, 4'h0, 4'hA, 4'h0, 4'hB, 4'h0,
              4'hC, 4'h0, 4'hD, 4'h0, 4'hE, 4'h0, 4'hF, 4'h0};
    check_trace("f_trace", tb_base);
    check("f_done_cnt", done_cnt - d_base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
